bcd_chain_ctrl: RTL

//  Run/stop controller for a chain of cascaded BCD decade counters (stopwatch/event-count style).

---
 rtl/bcd_ctrl_pkg.sv | 20 ++
 rtl/bcd_decade.sv | 29 ++
 rtl/bcd_chain_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/bcd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bcd_ctrl_pkg
// Brief   : Shared state encoding and digit constants for the BCD chain controller.
// Revision: 1.0
// ============================================================================
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int          DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

endpackage : bcd_ctrl_pkg
`default_nettype wire

// File: rtl/bcd_decade.sv
`default_nettype none
// ============================================================================
// Module  : bcd_decade
// Brief   : Single BCD digit (0..9) with enable, clear and a combinational carry.
// Revision: 1.0
// ============================================================================
module bcd_decade
    import bcd_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    output logic [DIGIT_W-1:0] q,
    output logic               carry_out
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= (q == BCD_MAX) ? '0 : q + 4'd1;
        end
    end

    assign carry_out = en && (q == BCD_MAX);

endmodule : bcd_decade
`default_nettype wire

// File: rtl/bcd_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : bcd_chain_ctrl
// Brief   : Run/stop FSM, tick prescaler and cascaded BCD decade chain.
//           Optional lap capture enabled by BCD_CTRL_LAP_CAPTURE_EN.
// Revision: 1.0
// ============================================================================
module bcd_chain_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10,
    parameter int WRAP     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      clear,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                      running,
    output logic                      done,
    output logic                      wrap
`ifdef BCD_CTRL_LAP_CAPTURE_EN
    ,
    input  logic                      lap,
    output logic [DIGIT_W*DIGITS-1:0] lap_out,
    output logic                      lap_valid
`endif
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    state_t                    r_state;
    logic [PS_W-1:0]           r_ps;
    logic                      r_running;
    logic                      r_done;
    logic                      r_wrap;
    logic [DIGIT_W*DIGITS-1:0] w_bcd;
    logic                      w_tick;
    logic                      w_all9;
    logic                      w_terminal;
    logic                      w_cnt_en;
    logic                      w_rollover;

    always_comb begin
        w_all9 = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_bcd[DIGIT_W*i +: DIGIT_W] != BCD_MAX) w_all9 = 1'b0;
        end
    end

    assign w_tick     = (r_state == RUN) && (r_ps == PS_LAST);
    assign w_terminal = w_tick && w_all9;
    // Saturating mode freezes the chain at all-9s instead of letting it roll over.
    assign w_cnt_en   = w_tick && !(w_terminal && (WRAP == 0));

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic en;
        logic carry;
        if (i == 0) begin : g_first
            assign en = w_cnt_en;
        end else begin : g_next
            assign en = g_digit[i-1].carry;
        end
        bcd_decade u_decade (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .clr       (clear),
            .q         (w_bcd[DIGIT_W*i +: DIGIT_W]),
            .carry_out (carry)
        );
    end

    // Carry out of the top digit is exactly the all-9s -> all-0s rollover.
    assign w_rollover = g_digit[DIGITS-1].carry;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state   <= IDLE;
            r_ps      <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_wrap <= w_rollover;
            if (r_state == RUN) begin
                r_ps <= w_tick ? '0 : r_ps + 1'b1;
            end
            case (r_state)
                IDLE, PAUSE: begin
                    if (start && !stop) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        r_state   <= PAUSE;
                        r_running <= 1'b0;
                    end else if (w_terminal && (WRAP == 0)) begin
                        r_state   <= DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bcd_out = w_bcd;
    assign running = r_running;
    assign done    = r_done;
    assign wrap    = r_wrap;

`ifdef BCD_CTRL_LAP_CAPTURE_EN
    logic                      r_lap_valid;
    logic [DIGIT_W*DIGITS-1:0] r_lap_out;
    logic                      w_lap_take;

    assign w_lap_take = lap && ((r_state == RUN) || (r_state == PAUSE));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_lap_valid <= 1'b0;
            r_lap_out   <= '0;
        end else begin
            r_lap_valid <= w_lap_take;
            if (w_lap_take) r_lap_out <= w_bcd;
        end
    end

    assign lap_out   = r_lap_out;
    assign lap_valid = r_lap_valid;
`endif

endmodule : bcd_chain_ctrl
`default_nettype wire
